spi_fifo_ctrl: RTL and testbench
================================

// Module: spi_fifo_ctrl
// PURPOSE
//   Parametrised synchronous FIFO for the SPI datapath: TX staging and RX capture buffer
//   between the bus-side register interface and the SPI shift engine. Supersedes the
//   single-mode SPI FIFO. Adds:
//   - true full at DATADEPTH entries
//   - accept/reject protection with sticky overflow/underflow flags
//   - programmable almost-full/almost-empty levels, synchronous flush
//   - selectable standard or first-word-fall-through (FWFT) read mode
// PARAMETERS
//   DATAWIDTH     8                     word width in bits
//   DATADEPTH     1024                  entries; power of 2, >= 4
//   ADDRESSWIDTH  $clog2(DATADEPTH)     pointer width (derived, do not override)
//   FWFT          0                     0 = standard read, 1 = first-word-fall-through
//   AFULL_LEVEL   DATADEPTH-4           almostFull  when wordCount >= AFULL_LEVEL
//   AEMPTY_LEVEL  4                     almostEmpty when wordCount <= AEMPTY_LEVEL
// PORTS
//   clk          in   1                 clock, all logic rising-edge
//   reset        in   1                 asynchronous, active-high reset
//   flush        in   1                 sync clear of contents (flags kept)
//   clearErrors  in   1                 sync clear of overflow/underflow
//   writeEn      in   1                 write request
//   dataIn       in   DATAWIDTH         write data
//   readReq      in   1                 read request (FWFT: pop head)
//   dataOut      out  DATAWIDTH         read data / head word
//   dataValid    out  1                 dataOut holds a valid word
//   wordCount    out  ADDRESSWIDTH+1    entries held, 0..DATADEPTH
//   empty        out  1                 no readable word
//   full         out  1                 wordCount == DATADEPTH
//   almostFull   out  1                 see AFULL_LEVEL
//   almostEmpty  out  1                 see AEMPTY_LEVEL
//   overflow     out  1                 sticky: write rejected
//   underflow    out  1                 sticky: read rejected
// BEHAVIOUR
//   Reset: pointers, wordCount = 0; dataOut = 0; dataValid = 0; empty = 1; full = 0;
//     almostEmpty = 1; almostFull = 0; overflow = underflow = 0.
//   Storage: synchronous-read RAM, DATADEPTH x DATAWIDTH. Pointers wrap modulo DATADEPTH.
//   Write accepted iff writeEn && !full. Full-cycle writes are rejected even with a
//     same-cycle read. A rejected write sets overflow and leaves state unchanged.
//   Read accepted iff readReq && !empty. A rejected read sets underflow; no pointer change.
//   wordCount: +1 on accepted write only; -1 on accepted read only; otherwise unchanged.
//   full, almostFull, almostEmpty are combinational from wordCount.
//   FWFT=0:
//     - empty = (wordCount == 0).
//     - Accepted read in cycle N: dataOut = word in cycle N+1, dataValid = 1 for that cycle.
//     - dataOut holds its value otherwise.
//   FWFT=1:
//     - Output register prefetches the head word.
//     - empty = !dataValid; dataOut = head while dataValid.
//     - A write into an empty FIFO in cycle N gives dataValid = 1 from cycle N+2.
//     - Back-to-back reads sustain one word per cycle with no bubble while wordCount >= 2.
//     - wordCount includes the word held in the output register.
//   flush: highest priority over reads and writes in the same cycle.
//     - Next cycle: wordCount = 0, pointers equal, dataValid = 0.
//     - dataOut and the error flags are unchanged.
//   clearErrors: clears both flags next cycle. A same-cycle new error wins (flag = 1).
//   reset asserted mid-transfer: immediate return to reset state; contents undefined.
// TESTING
//   1. Reset, write 0x01..0x04, then read 4 (FWFT=0) -> dataOut 0x01..0x04 on the cycle
//      after each read; wordCount 4->0; empty = 1.
//   2. DATADEPTH=8: write 8 -> full=1, wordCount=8; 9th write -> overflow=1, wordCount
//      stays 8; drain -> words in order; wrap check with 20 interleaved writes/reads.
//   3. Read while empty -> underflow=1, pointers unchanged; clearErrors -> underflow=0;
//      clearErrors with a same-cycle bad read -> underflow stays 1.
//   4. FWFT=1: write 0xA5 at cycle N -> dataValid=1, dataOut=0xA5 at N+2; preload 3 words,
//      3 consecutive reads -> 3 words in 3 cycles, then empty=1.
//   5. Simultaneous write+read at wordCount=5 -> wordCount stays 5; flush with same-cycle
//      writeEn -> wordCount=0, write dropped, no overflow.
//   6. AFULL_LEVEL=6, AEMPTY_LEVEL=2, DATADEPTH=8: step counts 0..8 -> almostEmpty for 0..2,
//      almostFull for 6..8; reset asserted at count 5 -> all outputs at reset values.

Source files
------------

// File: rtl/spi_fifo_ctrl.sv
// rtl/spi_fifo_ctrl.sv - SPI datapath FIFO with standard/FWFT read modes, level flags and sticky errors
module spi_fifo_ctrl #(
    parameter int DATAWIDTH    = 8,
    parameter int DATADEPTH    = 1024,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH),
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = DATADEPTH - 4,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clearErrors,
    input  logic                  writeEn,
    input  logic [DATAWIDTH-1:0]  dataIn,
    input  logic                  readReq,
    output logic [DATAWIDTH-1:0]  dataOut,
    output logic                  dataValid,
    output logic [ADDRESSWIDTH:0] wordCount,
    output logic                  empty,
    output logic                  full,
    output logic                  almostFull,
    output logic                  almostEmpty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                     CW       = ADDRESSWIDTH + 1;
    localparam logic [CW-1:0]          C_DEPTH  = CW'(DATADEPTH);
    localparam logic [CW-1:0]          C_AFULL  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0]          C_AEMPTY = CW'(AEMPTY_LEVEL);
    localparam logic [CW-1:0]          C_ONE_C  = CW'(1);
    localparam logic [ADDRESSWIDTH-1:0] C_ONE_A = ADDRESSWIDTH'(1);

    logic [DATAWIDTH-1:0]    r_mem [DATADEPTH];
    logic [ADDRESSWIDTH-1:0] r_wr_ptr;
    logic [ADDRESSWIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [DATAWIDTH-1:0]    r_dout;
    logic                    r_valid;
    logic                    r_ovf;
    logic                    r_udf;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_wr_rej;
    logic          w_rd_rej;
    logic [CW-1:0] w_ram_count;
    logic          w_ram_rd;
    logic          w_valid_nxt;

    // In FWFT mode the output register holds one counted word, so the RAM
    // holds wordCount minus that word; prefetch whenever the register is free.
    always_comb begin
        w_full      = (r_count == C_DEPTH);
        w_empty     = (FWFT != 0) ? !r_valid : (r_count == '0);
        w_wr_acc    = writeEn && !w_full && !flush;
        w_rd_acc    = readReq && !w_empty && !flush;
        w_wr_rej    = writeEn && w_full && !flush;
        w_rd_rej    = readReq && w_empty && !flush;
        w_ram_count = (FWFT != 0) ? (r_count - {{(CW-1){1'b0}}, r_valid}) : r_count;
        w_ram_rd    = w_rd_acc;
        w_valid_nxt = w_rd_acc;
        if (FWFT != 0) begin
            w_ram_rd    = !flush && (w_ram_count != '0) && (!r_valid || w_rd_acc);
            w_valid_nxt = !flush && (w_ram_rd || (r_valid && !w_rd_acc));
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= dataIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + C_ONE_A;
                end
                if (w_ram_rd) begin
                    r_rd_ptr <= r_rd_ptr + C_ONE_A;
                end
                if (w_wr_acc && !w_rd_acc) begin
                    r_count <= r_count + C_ONE_C;
                end else if (w_rd_acc && !w_wr_acc) begin
                    r_count <= r_count - C_ONE_C;
                end
            end
            if (w_ram_rd) begin
                r_dout <= r_mem[r_rd_ptr];
            end
            r_valid <= w_valid_nxt;
            // A new error in the clearing cycle must survive the clear.
            r_ovf   <= (r_ovf && !clearErrors) || w_wr_rej;
            r_udf   <= (r_udf && !clearErrors) || w_rd_rej;
        end
    end

    always_comb begin
        dataOut     = r_dout;
        dataValid   = r_valid;
        wordCount   = r_count;
        empty       = w_empty;
        full        = w_full;
        almostFull  = (r_count >= C_AFULL);
        almostEmpty = (r_count <= C_AEMPTY);
        overflow    = r_ovf;
        underflow   = r_udf;
    end

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// tb/tb_spi_fifo_ctrl.sv - self-checking bench for spi_fifo_ctrl in standard and FWFT modes
module tb_spi_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       clearErrors;
    logic       writeEn;
    logic [7:0] dataIn;
    logic       readReq;

    logic [7:0] dout0, dout1;
    logic       dv0, dv1;
    logic [3:0] cnt0, cnt1;
    logic       emp0, emp1, ful0, ful1, af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;

    int n_checks = 0;
    int n_err    = 0;
    int m_cnt    = 0;
    logic       sb_en = 1'b0;
    logic [7:0] sb_q[$];
    logic [7:0] fq[$];
    logic [7:0] last_exp = 8'h00;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [3:0] cnt;
        logic       ae;
        logic       af;
        logic       fu;
    } vec_t;
    vec_t vt[12];

    always #5 clk = ~clk;

    spi_fifo_ctrl #(.DATAWIDTH(8), .DATADEPTH(DEPTH), .FWFT(0), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush), .clearErrors(clearErrors),
        .writeEn(writeEn), .dataIn(dataIn), .readReq(readReq),
        .dataOut(dout0), .dataValid(dv0), .wordCount(cnt0), .empty(emp0), .full(ful0),
        .almostFull(af0), .almostEmpty(ae0), .overflow(ovf0), .underflow(udf0)
    );

    spi_fifo_ctrl #(.DATAWIDTH(8), .DATADEPTH(DEPTH), .FWFT(1), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush), .clearErrors(clearErrors),
        .writeEn(writeEn), .dataIn(dataIn), .readReq(readReq),
        .dataOut(dout1), .dataValid(dv1), .wordCount(cnt1), .empty(emp1), .full(ful1),
        .almostFull(af1), .almostEmpty(ae1), .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Standard-mode scoreboard: every valid output word must match the oldest accepted write.
    always @(negedge clk) begin
        if (sb_en && !reset && dv0) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %02h required no word", dout0);
            end else begin
                last_exp = sb_q.pop_front();
                if (dout0 !== last_exp) begin
                    n_err++;
                    $display("FAIL sb_data: got %02h required %02h", dout0, last_exp);
                end
            end
        end
    end

    task automatic step(input logic wr, input logic rd, input logic [7:0] d);
        logic wr_ok;
        logic rd_ok;
        wr_ok   = wr && (m_cnt < DEPTH);
        rd_ok   = rd && (m_cnt > 0);
        writeEn = wr;
        readReq = rd;
        dataIn  = d;
        if (wr_ok) sb_q.push_back(d);
        m_cnt = m_cnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
        @(posedge clk);
        #1;
        writeEn = 1'b0;
        readReq = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dout0"}, dout0, 0); chk({tag, "_dv0"}, dv0, 0);
        chk({tag, "_cnt0"}, cnt0, 0);   chk({tag, "_emp0"}, emp0, 1);
        chk({tag, "_ful0"}, ful0, 0);   chk({tag, "_ae0"}, ae0, 1);
        chk({tag, "_af0"}, af0, 0);     chk({tag, "_ovf0"}, ovf0, 0);
        chk({tag, "_udf0"}, udf0, 0);
        chk({tag, "_dout1"}, dout1, 0); chk({tag, "_dv1"}, dv1, 0);
        chk({tag, "_cnt1"}, cnt1, 0);   chk({tag, "_emp1"}, emp1, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; clearErrors = 1'b0;
        writeEn = 1'b0; readReq = 1'b0; dataIn = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        sb_en = 1'b1;

        // basic ordered write/read
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i));
        chk("t1_cnt4", cnt0, 4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
        chk("t1_cnt0", cnt0, 0);
        chk("t1_empty", emp0, 1);
        step(1'b0, 1'b0, 8'h00);
        chk("t1_drained", sb_q.size(), 0);

        // fill, overflow, drain, wrap with simultaneous write/read
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        chk("t2_full", ful0, 1);
        chk("t2_cnt8", cnt0, 8);
        step(1'b1, 1'b0, 8'hEE);
        chk("t2_ovf", ovf0, 1);
        chk("t2_cnt_hold", cnt0, 8);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        chk("t2_cnt_drain", cnt0, 0);
        step(1'b1, 1'b0, 8'h10);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'h11 + i));
        chk("t2_wrap_cnt", cnt0, 1);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("t2_wrap_drained", sb_q.size(), 0);
        clearErrors = 1'b1; step(1'b0, 1'b0, 8'h00); clearErrors = 1'b0;
        chk("t2_ovf_clr", ovf0, 0);

        // underflow and clearErrors priority
        step(1'b0, 1'b1, 8'h00);
        chk("t3_udf", udf0, 1);
        chk("t3_cnt", cnt0, 0);
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("t3_ptr_ok", sb_q.size(), 0);
        clearErrors = 1'b1; step(1'b0, 1'b0, 8'h00); clearErrors = 1'b0;
        chk("t3_udf_clr", udf0, 0);
        clearErrors = 1'b1; step(1'b0, 1'b1, 8'h00); clearErrors = 1'b0;
        chk("t3_udf_wins", udf0, 1);
        clearErrors = 1'b1; step(1'b0, 1'b0, 8'h00); clearErrors = 1'b0;

        // simultaneous write+read, flush with same-cycle write
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        step(1'b1, 1'b1, 8'h35);
        chk("t5_cnt5", cnt0, 5);
        step(1'b0, 1'b0, 8'h00);
        flush = 1'b1; writeEn = 1'b1; dataIn = 8'hAB;
        @(posedge clk);
        #1;
        flush = 1'b0; writeEn = 1'b0;
        sb_q.delete();
        m_cnt = 0;
        chk("t5_flush_cnt", cnt0, 0);
        chk("t5_flush_ovf", ovf0, 0);
        chk("t5_flush_dv", dv0, 0);
        chk("t5_flush_empty", emp0, 1);
        chk("t5_flush_dout", dout0, last_exp);
        step(1'b1, 1'b0, 8'h99);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("t5_write_dropped", sb_q.size(), 0);

        // level flags across counts 0..8 and back to 5
        vt[0] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        for (int i = 1; i <= 8; i++)
            vt[i] = '{1'b1, 1'b0, 4'(i), (i <= AE), (i >= AF), (i == DEPTH)};
        for (int i = 9; i < 12; i++)
            vt[i] = '{1'b0, 1'b1, 4'(16 - i), ((16 - i) <= AE), ((16 - i) >= AF), 1'b0};
        for (int i = 0; i < 12; i++) begin
            step(vt[i].wr, vt[i].rd, 8'(8'h40 + i));
            chk($sformatf("t6_cnt[%0d]", i), cnt0, vt[i].cnt);
            chk($sformatf("t6_ae[%0d]", i), ae0, vt[i].ae);
            chk($sformatf("t6_af[%0d]", i), af0, vt[i].af);
            chk($sformatf("t6_full[%0d]", i), ful0, vt[i].fu);
        end
        step(1'b0, 1'b0, 8'h00);
        #3;
        reset = 1'b1;
        #1;
        chk_reset("t6_midrst");
        sb_en = 1'b0;
        sb_q.delete();
        m_cnt = 0;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        // first-word-fall-through latency and bubble-free reads
        writeEn = 1'b1; dataIn = 8'hA5; fq.push_back(8'hA5);
        @(posedge clk);
        #1;
        writeEn = 1'b0;
        chk("t4_n1_dv", dv1, 0);
        chk("t4_n1_cnt", cnt1, 1);
        @(posedge clk);
        #1;
        chk("t4_n2_dv", dv1, 1);
        chk("t4_n2_dout", dout1, fq.pop_front());
        readReq = 1'b1;
        @(posedge clk);
        #1;
        readReq = 1'b0;
        chk("t4_pop_empty", emp1, 1);
        chk("t4_pop_cnt", cnt1, 0);
        for (int i = 0; i < 3; i++) begin
            writeEn = 1'b1; dataIn = 8'(8'hB1 + i); fq.push_back(dataIn);
            @(posedge clk);
            #1;
        end
        writeEn = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_pre_cnt", cnt1, 3);
        for (int i = 0; i < 3; i++) begin
            readReq = 1'b1;
            chk($sformatf("t4_b2b_dv[%0d]", i), dv1, 1);
            chk($sformatf("t4_b2b_dout[%0d]", i), dout1, fq.pop_front());
            @(posedge clk);
            #1;
        end
        readReq = 1'b0;
        chk("t4_end_empty", emp1, 1);
        chk("t4_end_cnt", cnt1, 0);
        chk("t4_end_udf", udf1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
